// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: opcodes, instruction field positions, immediate formats.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package rv32i_pkg;

    localparam int XLEN = 32;

    // Base opcodes (instr[6:0]); all legal RV32I opcodes end in 2'b11
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    // Instruction field bit positions
    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int F3_MSB  = 14;
    localparam int F3_LSB  = 12;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int F7_MSB  = 31;
    localparam int F7_LSB  = 25;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_type_t;

    // Contents of the decode holding register
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } dEntry_t;

endpackage

// File: rtl/rv32i_imm_gen.sv
// Immediate generator: classifies the instruction format by opcode and builds the sign-extended immediate.
// Latency: purely combinational.
// Backpressure: none.
// Ports: instr (32-bit word in), immType (format out), imm (32-bit immediate out).
module rv32i_imm_gen
    import rv32i_pkg::*;
(
    input  logic [XLEN-1:0] instr,
    output imm_type_t       immType,
    output logic [XLEN-1:0] imm
);

    always_comb begin
        immType = IMM_NONE;
        unique case (instr[OPC_MSB:OPC_LSB])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: immType = IMM_I;
            OPC_STORE:                                  immType = IMM_S;
            OPC_BRANCH:                                 immType = IMM_B;
            OPC_LUI, OPC_AUIPC:                         immType = IMM_U;
            OPC_JAL:                                    immType = IMM_J;
            default:                                    immType = IMM_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        unique case (immType)
            IMM_I: imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            // Branch and jump offsets are halfword-aligned: bit 0 is implicit zero
            IMM_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U: imm = {instr[31:12], 12'b0};
            IMM_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_decode_stage.sv
// Decode stage: holds one fetched instruction, drives register-file reads, presents decoded fields and operands.
// Latency: instruction accepted at edge N is presented to execute from N to N+1 (operands from a 1-cycle registered read).
// Backpressure: inReady = !dValid || outReady; a stalled instruction holds, its operands keep tracking write-backs.
// Ports: clk/resetn; fetch inValid/inReady/inInstr/inPc; flush; regfile rdAddrA/B, rdDataA/B; write-back snoop
//        wbWrite/wbAddr/wbData; execute outValid/outReady, outPc, outImm, outRs1Data, outRs2Data, outRd,
//        outOpcode, outFunct3, outFunct7, outIllegal.
module rv32i_decode_stage
    import rv32i_pkg::*;
(
    input  logic            clk,
    input  logic            resetn,
    input  logic            inValid,
    output logic            inReady,
    input  logic [XLEN-1:0] inInstr,
    input  logic [XLEN-1:0] inPc,
    input  logic            flush,
    output logic [4:0]      rdAddrA,
    output logic [4:0]      rdAddrB,
    input  logic [XLEN-1:0] rdDataA,
    input  logic [XLEN-1:0] rdDataB,
    input  logic            wbWrite,
    input  logic [4:0]      wbAddr,
    input  logic [XLEN-1:0] wbData,
    output logic            outValid,
    input  logic            outReady,
    output logic [XLEN-1:0] outPc,
    output logic [XLEN-1:0] outImm,
    output logic [XLEN-1:0] outRs1Data,
    output logic [XLEN-1:0] outRs2Data,
    output logic [4:0]      outRd,
    output logic [6:0]      outOpcode,
    output logic [2:0]      outFunct3,
    output logic [6:0]      outFunct7,
    output logic            outIllegal
);

    logic            dValid;
    dEntry_t         dReg;
    logic            bypA;
    logic            bypB;
    logic [XLEN-1:0] bypDataA;
    logic [XLEN-1:0] bypDataB;
    logic            accept;
    logic            hitA;
    logic            hitB;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    imm_type_t       immType;
    logic            knownOpcode;

    assign inReady = !dValid || outReady;
    assign accept  = inValid && inReady;

    // Address the file with whatever D will hold after this edge, so the data
    // arrives exactly when the instruction is presented. While stalled, D's
    // sources are re-read each cycle so later write-backs show up.
    assign rdAddrA = accept ? inInstr[RS1_MSB:RS1_LSB] : dReg.instr[RS1_MSB:RS1_LSB];
    assign rdAddrB = accept ? inInstr[RS2_MSB:RS2_LSB] : dReg.instr[RS2_MSB:RS2_LSB];

    // The file returns the pre-write value when read and written on the same
    // edge; capture the write-back data so it can replace that stale read.
    assign hitA = wbWrite && (wbAddr == rdAddrA) && (wbAddr != 5'd0);
    assign hitB = wbWrite && (wbAddr == rdAddrB) && (wbAddr != 5'd0);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            dValid   <= 1'b0;
            dReg     <= '0;
            bypA     <= 1'b0;
            bypB     <= 1'b0;
            bypDataA <= '0;
            bypDataB <= '0;
        end else begin
            // A redirect wins over a capture on the same edge
            if (flush) begin
                dValid <= 1'b0;
            end else if (accept) begin
                dValid     <= 1'b1;
                dReg.instr <= inInstr;
                dReg.pc    <= inPc;
            end else if (dValid && outReady) begin
                dValid <= 1'b0;
            end

            bypA <= hitA;
            bypB <= hitB;
            if (hitA) begin
                bypDataA <= wbData;
            end
            if (hitB) begin
                bypDataB <= wbData;
            end
        end
    end

    rv32i_imm_gen uImmGen (
        .instr   (dReg.instr),
        .immType (immType),
        .imm     (outImm)
    );

    assign rs1 = dReg.instr[RS1_MSB:RS1_LSB];
    assign rs2 = dReg.instr[RS2_MSB:RS2_LSB];

    assign outRs1Data = (rs1 == 5'd0) ? '0 : (bypA ? bypDataA : rdDataA);
    assign outRs2Data = (rs2 == 5'd0) ? '0 : (bypB ? bypDataB : rdDataB);

    assign outValid  = dValid;
    assign outPc     = dReg.pc;
    assign outRd     = dReg.instr[RD_MSB:RD_LSB];
    assign outOpcode = dReg.instr[OPC_MSB:OPC_LSB];
    assign outFunct3 = dReg.instr[F3_MSB:F3_LSB];
    assign outFunct7 = dReg.instr[F7_MSB:F7_LSB];

    // Every opcode with an immediate format is legal; OP and MISC-MEM are the
    // only legal opcodes without one.
    assign knownOpcode = (immType != IMM_NONE)
                      || (outOpcode == OPC_OP)
                      || (outOpcode == OPC_MISC_MEM);

    assign outIllegal = dValid && ((dReg.instr[1:0] != 2'b11) || !knownOpcode);

endmodule

// File: tb/tb_rv32i_decode_stage.sv
// Bench for rv32i_decode_stage: directed scenarios plus randomized traffic against a behavioural model.
// Latency: n/a.
// Backpressure: n/a.
module tb_rv32i_decode_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        inValid;
    logic        inReady;
    logic [31:0] inInstr;
    logic [31:0] inPc;
    logic        flush;
    logic [4:0]  rdAddrA;
    logic [4:0]  rdAddrB;
    logic [31:0] rdDataA;
    logic [31:0] rdDataB;
    logic        wbWrite;
    logic [4:0]  wbAddr;
    logic [31:0] wbData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outPc;
    logic [31:0] outImm;
    logic [31:0] outRs1Data;
    logic [31:0] outRs2Data;
    logic [4:0]  outRd;
    logic [6:0]  outOpcode;
    logic [2:0]  outFunct3;
    logic [6:0]  outFunct7;
    logic        outIllegal;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the instruction decode currently owns, and the
    // architectural register contents as seen after each edge's write-back.
    bit          mValid = 1'b0;
    logic [31:0] mInstr = '0;
    logic [31:0] mPc    = '0;
    logic [31:0] archReg [32];

    always #5 clk = ~clk;

    // Register file: registered read, old data returned on a same-edge write
    logic [31:0] rfMem [32];
    always @(posedge clk) begin
        if (wbWrite && wbAddr != 5'd0) rfMem[wbAddr] <= wbData;
        rdDataA <= rfMem[rdAddrA];
        rdDataB <= rfMem[rdAddrB];
    end

    rv32i_decode_stage dut (
        .clk        (clk),
        .resetn     (resetn),
        .inValid    (inValid),
        .inReady    (inReady),
        .inInstr    (inInstr),
        .inPc       (inPc),
        .flush      (flush),
        .rdAddrA    (rdAddrA),
        .rdAddrB    (rdAddrB),
        .rdDataA    (rdDataA),
        .rdDataB    (rdDataB),
        .wbWrite    (wbWrite),
        .wbAddr     (wbAddr),
        .wbData     (wbData),
        .outValid   (outValid),
        .outReady   (outReady),
        .outPc      (outPc),
        .outImm     (outImm),
        .outRs1Data (outRs1Data),
        .outRs2Data (outRs2Data),
        .outRd      (outRd),
        .outOpcode  (outOpcode),
        .outFunct3  (outFunct3),
        .outFunct7  (outFunct7),
        .outIllegal (outIllegal)
    );

    // Immediate computed arithmetically from the ISA's bit scatter
    function automatic logic [31:0] expImm(input logic [31:0] ins);
        int v;
        case (ins[6:0])
            7'h03, 7'h13, 7'h67, 7'h73: v = $signed(ins) >>> 20;
            7'h23: v = ($signed(ins) >>> 25) * 32 + int'(ins[11:7]);
            7'h63: v = int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2
                       - int'(ins[31]) * 4096;
            7'h37, 7'h17: v = int'(ins & 32'hFFFFF000);
            7'h6F: v = int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2
                       - int'(ins[31]) * (1 << 20);
            default: v = 0;
        endcase
        return v;
    endfunction

    function automatic bit expIllegal(input logic [31:0] ins);
        return !(ins[6:0] inside {7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h0F, 7'h73});
    endfunction

    function automatic logic [31:0] randInstr();
        logic [31:0] r;
        logic [6:0]  opc;
        r = $urandom;
        case ($urandom_range(0, 11))
            0: opc = 7'h37;  1: opc = 7'h17;  2: opc = 7'h6F;  3: opc = 7'h67;
            4: opc = 7'h63;  5: opc = 7'h03;  6: opc = 7'h23;  7: opc = 7'h13;
            8: opc = 7'h33;  9: opc = 7'h0F;  10: opc = 7'h73;
            default: return r;
        endcase
        return {r[31:7], opc};
    endfunction

    function automatic logic [31:0] expRs(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : archReg[r];
    endfunction

    task automatic idle();
        inValid  = 1'b0;
        inInstr  = '0;
        inPc     = '0;
        flush    = 1'b0;
        wbWrite  = 1'b0;
        wbAddr   = '0;
        wbData   = '0;
        outReady = 1'b1;
    endtask

    // Advance one clock edge and update the model from the inputs held across it;
    // returns on the following falling edge.
    task automatic step();
        bit acc;
        acc = inValid && (!mValid || outReady);
        @(posedge clk);
        if (!resetn) begin
            mValid = 1'b0; mInstr = '0; mPc = '0;
        end else if (flush) begin
            mValid = 1'b0;
        end else if (acc) begin
            mValid = 1'b1; mInstr = inInstr; mPc = inPc;
        end else if (mValid && outReady) begin
            mValid = 1'b0;
        end
        if (wbWrite && wbAddr != 5'd0) archReg[wbAddr] = wbData;
        @(negedge clk);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        step();
        step();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid: got %b want 0", outValid); end
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady: got %b want 1", inReady); end
        checks++; if (outPc !== 32'd0) begin errors++; $display("FAIL reset_outPc: got %h want 0", outPc); end
        checks++; if (outImm !== 32'd0) begin errors++; $display("FAIL reset_outImm: got %h want 0", outImm); end
        checks++; if (outRd !== 5'd0) begin errors++; $display("FAIL reset_outRd: got %h want 0", outRd); end
        checks++; if (outRs1Data !== 32'd0 || outRs2Data !== 32'd0) begin
            errors++; $display("FAIL reset_rsData: got %h/%h want 0/0", outRs1Data, outRs2Data); end
        checks++; if (outIllegal !== 1'b0) begin errors++; $display("FAIL reset_outIllegal: got %b want 0", outIllegal); end
        resetn = 1'b1;
        step();
    endtask

    task automatic preload();
        for (int r = 1; r < 32; r++) begin
            wbWrite = 1'b1; wbAddr = 5'(r); wbData = $urandom;
            step();
        end
        idle();
        step();
    endtask

    task automatic test_addi();
        idle();
        inValid = 1'b1; inInstr = 32'h00A00293; inPc = 32'h100;
        step();
        idle();
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL addi_outValid: got %b want 1", outValid); end
        checks++; if (outRd !== 5'd5) begin errors++; $display("FAIL addi_outRd: got %0d want 5", outRd); end
        checks++; if (outOpcode !== 7'h13) begin errors++; $display("FAIL addi_outOpcode: got %h want 13", outOpcode); end
        checks++; if (outImm !== 32'd10) begin errors++; $display("FAIL addi_outImm: got %h want a", outImm); end
        checks++; if (outRs1Data !== 32'd0) begin errors++; $display("FAIL addi_outRs1Data: got %h want 0", outRs1Data); end
        checks++; if (outPc !== 32'h100) begin errors++; $display("FAIL addi_outPc: got %h want 100", outPc); end
        step();
    endtask

    task automatic test_collision();
        idle();
        wbWrite = 1'b1; wbAddr = 5'd1; wbData = 32'd7;
        step();
        wbAddr = 5'd2; wbData = 32'h22;
        step();
        // add x3,x1,x2 accepted on the same edge x1 is rewritten
        inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h180;
        wbWrite = 1'b1; wbAddr = 5'd1; wbData = 32'h55;
        step();
        idle();
        outReady = 1'b0;
        checks++; if (outRs1Data !== 32'h55) begin errors++; $display("FAIL collision_rs1: got %h want 55", outRs1Data); end
        checks++; if (outRs2Data !== 32'h22) begin errors++; $display("FAIL collision_rs2: got %h want 22", outRs2Data); end
        checks++; if (outRd !== 5'd3 || outOpcode !== 7'h33) begin
            errors++; $display("FAIL collision_fields: got rd %0d op %h want 3/33", outRd, outOpcode); end
        step();
        checks++; if (outRs1Data !== 32'h55) begin errors++; $display("FAIL collision_rs1_held: got %h want 55", outRs1Data); end
        outReady = 1'b1;
        step();
    endtask

    task automatic test_stall();
        idle();
        outReady = 1'b0;
        inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h200;
        step();
        inInstr = 32'h00A00293; inPc = 32'h204;
        wbWrite = 1'b1; wbAddr = 5'd2; wbData = 32'h99;
        #1;
        checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL stall_inReady: got %b want 0", inReady); end
        checks++; if (rdAddrB !== 5'd2) begin errors++; $display("FAIL stall_rdAddrB: got %0d want 2", rdAddrB); end
        step();
        wbWrite = 1'b0;
        checks++; if (outRs2Data !== 32'h99) begin errors++; $display("FAIL stall_rs2_bypass: got %h want 99", outRs2Data); end
        checks++; if (outPc !== 32'h200 || outRd !== 5'd3 || outValid !== 1'b1) begin
            errors++; $display("FAIL stall_hold: got pc %h rd %0d v %b want 200/3/1", outPc, outRd, outValid); end
        step();
        checks++; if (outRs2Data !== 32'h99) begin errors++; $display("FAIL stall_rs2_file: got %h want 99", outRs2Data); end
        step();
        checks++; if (outPc !== 32'h200 || outValid !== 1'b1) begin
            errors++; $display("FAIL stall_hold3: got pc %h v %b want 200/1", outPc, outValid); end
        outReady = 1'b1;
        #1;
        checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL stall_release_inReady: got %b want 1", inReady); end
        step();
        checks++; if (outPc !== 32'h204 || outRd !== 5'd5 || outValid !== 1'b1) begin
            errors++; $display("FAIL stall_advance: got pc %h rd %0d v %b want 204/5/1", outPc, outRd, outValid); end
        idle();
        step();
    endtask

    task automatic test_x0();
        idle();
        inValid = 1'b1; inInstr = 32'h00A00293; inPc = 32'h280;
        wbWrite = 1'b1; wbAddr = 5'd0; wbData = 32'hFFFFFFFF;
        step();
        idle();
        outReady = 1'b0;
        checks++; if (outRs1Data !== 32'd0) begin errors++; $display("FAIL x0_rs1: got %h want 0", outRs1Data); end
        step();
        checks++; if (outRs1Data !== 32'd0) begin errors++; $display("FAIL x0_rs1_held: got %h want 0", outRs1Data); end
        outReady = 1'b1;
        step();
    endtask

    task automatic test_illegal_branch();
        idle();
        inValid = 1'b1; inInstr = 32'hFFFFFFFF; inPc = 32'h300;
        step();
        checks++; if (outIllegal !== 1'b1 || outValid !== 1'b1) begin
            errors++; $display("FAIL illegal_flag: got ill %b v %b want 1/1", outIllegal, outValid); end
        // back-to-back: beq x0,x0,-4 replaces it with no bubble
        inInstr = 32'hFE000EE3; inPc = 32'h304;
        step();
        idle();
        checks++; if (outImm !== 32'hFFFFFFFC) begin errors++; $display("FAIL branch_imm: got %h want fffffffc", outImm); end
        checks++; if (outIllegal !== 1'b0 || outPc !== 32'h304) begin
            errors++; $display("FAIL branch_legal: got ill %b pc %h want 0/304", outIllegal, outPc); end
        step();
    endtask

    task automatic test_flush();
        idle();
        outReady = 1'b0;
        inValid = 1'b1; inInstr = 32'h00A00293; inPc = 32'h380;
        step();
        flush = 1'b1; inInstr = 32'h002081B3; inPc = 32'h384;
        step();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_stall: got outValid %b want 0", outValid); end
        flush = 1'b0;
        step();
        checks++; if (outValid !== 1'b1 || outPc !== 32'h384) begin
            errors++; $display("FAIL flush_refill: got v %b pc %h want 1/384", outValid, outPc); end
        outReady = 1'b1; flush = 1'b1; inPc = 32'h388;
        step();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL flush_over_accept: got outValid %b want 0", outValid); end
        idle();
        step();
    endtask

    task automatic test_reset_mid_stall();
        idle();
        outReady = 1'b0;
        inValid = 1'b1; inInstr = 32'h002081B3; inPc = 32'h400;
        step();
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL rst_stall_setup: got outValid %b want 1", outValid); end
        resetn = 1'b0;
        #1;
        mValid = 1'b0; mInstr = '0; mPc = '0;
        checks++; if (outValid !== 1'b0 || inReady !== 1'b1) begin
            errors++; $display("FAIL rst_async: got v %b rdy %b want 0/1", outValid, inReady); end
        checks++; if (outPc !== 32'd0 || outRd !== 5'd0 || outImm !== 32'd0 || outIllegal !== 1'b0) begin
            errors++; $display("FAIL rst_async_fields: got pc %h rd %0d imm %h ill %b want zeros", outPc, outRd, outImm, outIllegal); end
        checks++; if (outRs1Data !== 32'd0 || outRs2Data !== 32'd0) begin
            errors++; $display("FAIL rst_async_rs: got %h/%h want 0/0", outRs1Data, outRs2Data); end
        step();
        resetn = 1'b1;
        idle();
        step();
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_release: got outValid %b want 0", outValid); end
    endtask

    task automatic test_random();
        logic [4:0] eA;
        logic [4:0] eB;
        bit         acc;
        for (int n = 0; n < 600; n++) begin
            inValid  = ($urandom_range(0, 3) != 0);
            inInstr  = randInstr();
            inPc     = $urandom;
            outReady = ($urandom_range(0, 2) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            wbWrite  = $urandom_range(0, 1);
            wbAddr   = 5'($urandom_range(0, 31));
            wbData   = $urandom;
            #1;
            acc = inValid && (!mValid || outReady);
            eA  = acc ? inInstr[19:15] : mInstr[19:15];
            eB  = acc ? inInstr[24:20] : mInstr[24:20];
            checks++; if (inReady !== (!mValid || outReady)) begin
                errors++; $display("FAIL rnd_inReady[%0d]: got %b want %b", n, inReady, !mValid || outReady); end
            checks++; if (rdAddrA !== eA || rdAddrB !== eB) begin
                errors++; $display("FAIL rnd_rdAddr[%0d]: got %0d/%0d want %0d/%0d", n, rdAddrA, rdAddrB, eA, eB); end
            step();
            checks++; if (outValid !== mValid || outPc !== mPc) begin
                errors++; $display("FAIL rnd_valid_pc[%0d]: got %b/%h want %b/%h", n, outValid, outPc, mValid, mPc); end
            checks++; if (outRd !== mInstr[11:7] || outOpcode !== mInstr[6:0]
                          || outFunct3 !== mInstr[14:12] || outFunct7 !== mInstr[31:25]) begin
                errors++; $display("FAIL rnd_fields[%0d]: instr %h got rd %0d op %h f3 %0d f7 %h", n, mInstr, outRd, outOpcode, outFunct3, outFunct7); end
            checks++; if (outImm !== expImm(mInstr)) begin
                errors++; $display("FAIL rnd_imm[%0d]: instr %h got %h want %h", n, mInstr, outImm, expImm(mInstr)); end
            checks++; if (outIllegal !== (mValid && expIllegal(mInstr))) begin
                errors++; $display("FAIL rnd_illegal[%0d]: instr %h got %b want %b", n, mInstr, outIllegal, mValid && expIllegal(mInstr)); end
            if (mValid) begin
                checks++; if (outRs1Data !== expRs(mInstr[19:15]) || outRs2Data !== expRs(mInstr[24:20])) begin
                    errors++; $display("FAIL rnd_operands[%0d]: instr %h got %h/%h want %h/%h", n, mInstr,
                                       outRs1Data, outRs2Data, expRs(mInstr[19:15]), expRs(mInstr[24:20])); end
            end
        end
        idle();
        step();
    endtask

    initial begin
        for (int r = 0; r < 32; r++) archReg[r] = '0;
        resetn = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        preload();
        test_addi();
        test_collision();
        test_stall();
        test_x0();
        test_illegal_branch();
        test_flush();
        test_random();
        test_reset_mid_stall();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
